// File: rtl/spio_hss_multiplexer_frame_disassembler.sv
// Receive-side HSS frame disassembler: checks length, checksum and sequence of
// incoming data frames. Packets wait in staging until the trailer verifies, then
// go out on 8 per-channel packet ports. ACK/NAK responses go back to the local
// frame assembler, and per-channel flow-control state goes back across the link.
//
// state   | meaning
// IDLE    | waiting for a data-frame header; other words ignored
// BODY    | storing key/payload words into staging, accumulating checksum
// DISCARD | frame already known bad (too long); consuming words until trailer
// CHECK   | one-cycle verdict: reject, out-of-sequence drop, or commit
module spio_hss_multiplexer_frame_disassembler #(
  parameter int         SEQ_BITS   = 7,
  parameter logic [3:0] DATA_KBITS = 4'b0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         frm_data,
  input  logic [3:0]          frm_kchr,
  input  logic                frm_last,
  input  logic                frm_vld,
  output logic                frm_rdy,
  output logic [575:0]        pkt_data,
  output logic [7:0]          pkt_vld,
  input  logic [7:0]          pkt_rdy,
  output logic                ack_type,
  output logic                ack_colour,
  output logic [SEQ_BITS-1:0] ack_seq,
  output logic                ack_vld,
  output logic [7:0]          cfc_loc,
  output logic                reg_rfrm,
  output logic                reg_bfrm,
  output logic                reg_oseq
);

  typedef enum logic [1:0] {IDLE, BODY, CHECK, DISCARD} state_t;

  state_t              state, state_nxt;
  logic [7:0]          p_mask, l_mask, rem, cur_oh;
  logic                phase;
  logic [SEQ_BITS-1:0] frm_seq, exp_seq, seq_inc;
  logic                frm_colour, nak_pend, err;
  logic [31:0]         csum;
  logic [4:0]          count, n_exp;
  logic [31:0]         stage_key [8];
  logic [31:0]         stage_pld [8];
  logic                acc, is_hdr, overrun, fail, seq_bad;
  logic                do_bad, do_oseq, do_commit, hdr_bad, body_store;
  logic [7:0]          pkt_vld_nxt;

  function automatic logic [4:0] popcount8(input logic [7:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Short packets carry a zero payload; parity bit makes the 72-bit packet odd.
  function automatic logic [71:0] build_pkt(input logic [31:0] key,
                                            input logic [31:0] pld,
                                            input logic        lng);
    logic [31:0] p;
    logic        par;
    p   = lng ? pld : 32'h0;
    par = ~^{key, p, lng};
    return {p, key, 6'b0, lng, par};
  endfunction

  assign acc        = frm_vld & frm_rdy;
  assign is_hdr     = (frm_kchr == DATA_KBITS);
  assign n_exp      = popcount8(p_mask) + popcount8(l_mask);
  assign cur_oh     = rem & (~rem + 8'd1);
  assign seq_inc    = exp_seq + SEQ_BITS'(1);
  assign body_store = (state == BODY) && acc && !frm_last && (count != n_exp);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && is_hdr && !frm_last) state_nxt = BODY;
      BODY:    if (acc) begin
                 if (frm_last)            state_nxt = CHECK;
                 else if (count == n_exp) state_nxt = DISCARD;
               end
      DISCARD: if (acc && frm_last) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready, CHECK verdict and next packet-valid vector
  always_comb begin
    frm_rdy     = rst && (state != CHECK);
    overrun     = |(p_mask & pkt_vld);
    fail        = err | overrun;
    seq_bad     = (frm_seq != exp_seq);
    do_bad      = (state == CHECK) && fail;
    do_oseq     = (state == CHECK) && !fail && seq_bad;
    do_commit   = (state == CHECK) && !fail && !seq_bad;
    hdr_bad     = (state == IDLE) && acc && is_hdr && frm_last;
    pkt_vld_nxt = (pkt_vld & ~pkt_rdy) | (do_commit ? p_mask : 8'h00);
  end

  // Frame parsing: header latch, body word count, channel walk and checksum
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_mask     <= '0;
      l_mask     <= '0;
      rem        <= '0;
      phase      <= 1'b0;
      frm_seq    <= '0;
      frm_colour <= 1'b0;
      csum       <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc && is_hdr && !frm_last) begin
          p_mask     <= frm_data[31:24];
          l_mask     <= frm_data[23:16] & frm_data[31:24];
          rem        <= frm_data[31:24];
          phase      <= 1'b0;
          frm_colour <= frm_data[15];
          frm_seq    <= frm_data[8 +: SEQ_BITS];
          csum       <= frm_data;
          count      <= '0;
          err        <= 1'b0;
        end
        BODY: if (acc) begin
          if (frm_last) begin
            err <= (count != n_exp) || (csum != frm_data);
          end else if (count == n_exp) begin
            err <= 1'b1;
          end else begin
            csum  <= csum ^ frm_data;
            count <= count + 5'd1;
            if (phase) begin
              phase <= 1'b0;
              rem   <= rem & ~cur_oh;
            end else if (|(cur_oh & l_mask)) begin
              phase <= 1'b1;
            end else begin
              rem <= rem & ~cur_oh;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Staging registers; contents only matter once a whole frame has verified
  always_ff @(posedge clk) begin
    if (body_store) begin
      for (int i = 0; i < 8; i++) begin
        if (cur_oh[i]) begin
          if (phase) stage_pld[i] <= frm_data;
          else       stage_key[i] <= frm_data;
        end
      end
    end
  end

  // Verdict actions: responses, sequence tracking, packet release and flow control
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_seq    <= '0;
      nak_pend   <= 1'b0;
      pkt_vld    <= '0;
      pkt_data   <= '0;
      cfc_loc    <= 8'hFF;
      ack_vld    <= 1'b0;
      ack_type   <= 1'b0;
      ack_colour <= 1'b0;
      ack_seq    <= '0;
      reg_rfrm   <= 1'b0;
      reg_bfrm   <= 1'b0;
      reg_oseq   <= 1'b0;
    end else begin
      ack_vld  <= 1'b0;
      reg_rfrm <= 1'b0;
      reg_bfrm <= do_bad | hdr_bad;
      reg_oseq <= do_oseq;
      pkt_vld  <= pkt_vld_nxt;
      cfc_loc  <= ~pkt_vld_nxt;
      // Only the first rejection after a good frame is NAKed; repeats stay silent
      if ((do_bad || do_oseq) && !nak_pend) begin
        ack_vld    <= 1'b1;
        ack_type   <= 1'b1;
        ack_colour <= frm_colour;
        ack_seq    <= exp_seq;
        nak_pend   <= 1'b1;
      end
      if (do_commit) begin
        exp_seq    <= seq_inc;
        ack_vld    <= 1'b1;
        ack_type   <= 1'b0;
        ack_colour <= frm_colour;
        ack_seq    <= seq_inc;
        nak_pend   <= 1'b0;
        reg_rfrm   <= 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (p_mask[i]) pkt_data[72*i +: 72] <= build_pkt(stage_key[i], stage_pld[i], l_mask[i]);
        end
      end
    end
  end

endmodule

// File: doc/spio_hss_multiplexer_frame_disassembler.md
Name: spio_hss_multiplexer_frame_disassembler

Overview:
Receive-side counterpart of the HSS multiplexer frame assembler. It accepts decoded frame words from the link, checks frame length, checksum and sequence number, and splits good frames into per-channel SpiNNaker packets on 8 output channels. It returns ACK/NAK indications to the local frame assembler and drives per-channel flow-control state back across the link. Packets from a frame are held in staging until the frame trailer verifies, so bad frames never release packets.

Parameters:
SEQ_BITS, 7, width of frame sequence number and ack_seq (1..7)
DATA_KBITS, 4'b0001, frm_kchr value identifying a data-frame header word

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
frm_data  in  32  frame word
frm_kchr  in  4  per-byte K-character flags
frm_last  in  1  word is frame trailer
frm_vld  in  1  word valid
frm_rdy  out  1  word accepted when frm_vld & frm_rdy
pkt_data  out  576  8 x 72-bit packets, channel i at [72*i+71:72*i], format {pld,key,hdr}
pkt_vld  out  8  per-channel packet valid
pkt_rdy  in  8  per-channel packet ready
ack_type  out  1  0 = ACK, 1 = NAK
ack_colour  out  1  colour bit of the triggering frame
ack_seq  out  SEQ_BITS  ACK: next expected seq; NAK: expected seq
ack_vld  out  1  single-cycle response strobe
cfc_loc  out  8  bit i = 1: channel i output empty, may receive
reg_rfrm  out  1  pulse: good frame committed
reg_bfrm  out  1  pulse: frame failed length/checksum/overrun
reg_oseq  out  1  pulse: good frame dropped as out-of-sequence

Behaviour:
- Frame format: header word (kchr == DATA_KBITS); [31:24] present mask P; [23:16] long mask L (bits outside P ignored); [15] colour; [8+SEQ_BITS-1:8] seq; [7:0] K-code, ignored. Body: for each set bit of P in ascending channel order, a key word, then a payload word if the L bit is set. Trailer: frm_last=1, equals the XOR of the header and all body words.
- Expected body length N = popcount(P) + popcount(P & L), range 0..16.
- Packet rebuild: hdr = {6'b0, long, par}, pld = 0 when short, par = ~^{key, pld, long}, giving odd parity over 72 bits.
- FSM IDLE/BODY/CHECK/DISCARD; frm_rdy = 1 except in CHECK.
  - IDLE: non-header words are ignored. A header with frm_last=1 raises reg_bfrm and stays in IDLE. Any other header latches P, L, seq and colour, seeds the checksum, sets the word count to 0 and moves to BODY.
  - BODY: non-last words go to the staging register of the current channel, with the checksum accumulated. frm_last moves to CHECK with length_ok = (count == N). A non-last word when count == N sets bad and moves to DISCARD.
  - DISCARD: consumes words until frm_last, then goes to CHECK with bad set.
  - CHECK: one cycle; evaluate as below, then return to IDLE.
- Evaluation, in priority order:
  - Bad, length error, checksum mismatch, or any present channel with pkt_vld still 1 (overrun): reg_bfrm=1. If nak_pend=0, emit NAK with ack_seq = exp_seq and set nak_pend.
  - seq != exp_seq: reg_oseq=1. If nak_pend=0, emit NAK(exp_seq) and set nak_pend; otherwise no response.
  - Otherwise commit: staging copies to the output of every present channel, setting pkt_vld; exp_seq increments with wrap mod 2^SEQ_BITS; ACK with ack_seq = new exp_seq; nak_pend cleared; reg_rfrm=1.
- Response strobes (ack_vld, reg_*) assert in the cycle after CHECK and last exactly 1 cycle.
- Output handshake: pkt_vld[i] stays 1 and pkt_data stays stable until pkt_rdy[i]. Independent per channel. A commit and a pkt_rdy in the same cycle cannot collide because overrun is rejected. cfc_loc[i] = ~pkt_vld[i], registered.
- An empty frame (P=0) with a good trailer and matching seq commits nothing but ACKs and advances exp_seq.
- Reset (rst=0, sampled at clk) gives:
  - FSM IDLE, exp_seq=0, nak_pend=0
  - pkt_vld=0, pkt_data=0
  - ack_vld=0, ack_type=0, ack_colour=0, ack_seq=0
  - reg_*=0, cfc_loc=8'hFF, frm_rdy=0 during reset
  - Reset mid-frame discards staging with no response.

Test Plan:
- Reset, then frame seq 0, P=8'h81, L=8'h80: ch0 key 0x1, ch7 key 0x11100001 / pld 0x5a5a5a5a, correct trailer -> pkt_vld=8'h81; ch7 pkt_data = {0x5a5a5a5a, 0x11100001, 8'h02|par}; ACK seq 1; reg_rfrm pulse.
- Same frame with trailer bit 0 flipped -> no pkt_vld, NAK seq 0, reg_bfrm. Resend with seq 1 -> reg_oseq, no ack_vld. Resend correct seq 0 -> ACK 1.
- Header P=8'h01 followed by 3 body words then trailer -> reg_bfrm, NAK 0, no packet released.
- ch0 pkt_rdy held 0, second good frame for ch0 -> overrun, NAK, cfc_loc[0]=0 throughout. Release pkt_rdy -> cfc_loc[0]=1, retransmit -> ACK.
- 128 consecutive good empty frames (P=0), seq 0..127 -> ack_seq 1..127 then 0 (wrap).
- rst low mid-BODY of ch3 frame -> all outputs at reset values; the next good seq-0 frame is accepted.
